data_mem_responder: RTL and testbench



---
 rtl/mem_pkg.sv | 40 ++++
 rtl/mem_lane_align.sv | 68 ++++++
 rtl/data_mem_responder.sv | 196 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data-memory responder and its lane aligner:
// access-size encodings, responder FSM states, the response record and the
// alignment check used to classify faulting requests.
// ---------------------------------------------------------------------------
package mem_pkg;

  // Access-size encodings carried on req_size
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
  } resp_t;

  // Half accesses need addr[0]==0, word accesses need addr[1:0]==0.
  // Byte accesses are always aligned; the illegal size is classified elsewhere.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SIZE_H:  mis = addr_lo[0];
      SIZE_W:  mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align
// Combinational byte-lane steering between a right-aligned CPU operand and
// a 32-bit little-endian RAM word.
//   i_size      access size (SIZE_B/H/W; SIZE_X yields all zeros)
//   i_addr_lo   byte offset within the word
//   i_unsigned  1 = zero-extend loads, 0 = sign-extend (ignored for words)
//   i_wdata     right-aligned store data
//   i_rword     raw RAM word read at the access index
//   o_byte_en   byte lanes written by a store
//   o_wdata     store data replicated onto every candidate lane
//   o_rdata     selected load lane, extended to 32 bits
// ---------------------------------------------------------------------------
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection for stores (enables + replicated data) and loads (extract + extend)
  always_comb begin
    o_byte_en = 4'b0000;
    o_wdata   = 32'h0000_0000;
    o_rdata   = 32'h0000_0000;
    w_byte    = 8'h00;
    w_half    = 16'h0000;
    case (i_size)
      SIZE_B: begin
        o_byte_en = 4'b0001 << i_addr_lo;
        o_wdata   = {4{i_wdata[7:0]}};
        case (i_addr_lo)
          2'b00:   w_byte = i_rword[7:0];
          2'b01:   w_byte = i_rword[15:8];
          2'b10:   w_byte = i_rword[23:16];
          default: w_byte = i_rword[31:24];
        endcase
        o_rdata = i_unsigned ? {24'h00_0000, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      SIZE_H: begin
        o_byte_en = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata   = {2{i_wdata[15:0]}};
        w_half    = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];
        o_rdata   = i_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
      end
      SIZE_W: begin
        o_byte_en = 4'b1111;
        o_wdata   = i_wdata;
        o_rdata   = i_rword;
      end
      default: begin
        o_byte_en = 4'b0000;
        o_wdata   = 32'h0000_0000;
        o_rdata   = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the CPU load/store port. Accepts one request at
// a time, holds it for WAIT_CYCLES wait states, performs a byte/half/word
// access on an internal word-organised RAM and returns the result over a
// valid/ready response channel. Faulting requests skip the wait states and
// never touch the RAM.
//   clock, reset   single clock, synchronous active-high reset
//   req_*          request channel (valid/ready), sampled only at acceptance
//   resp_*         response channel (valid/ready); rdata is 0 for stores and
//                  faults, error flags illegal size, misalignment or range
// ---------------------------------------------------------------------------
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  // Counter only ever holds WAIT_CYCLES-1; keep at least one bit for WAIT_CYCLES=0
  localparam int unsigned CW = $clog2(WAIT_CYCLES + 2);
  localparam logic [CW-1:0] CNT_LOAD  = CW'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  // Byte span of the RAM, one bit wider so DEPTH_WORDS*4 == 2**32 still compares
  localparam logic [32:0]   SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam bit            ZERO_WAIT  = (WAIT_CYCLES == 0);

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic            w_do_access;

  logic            r_write;
  logic [1:0]      r_size;
  logic            r_unsigned;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  resp_t           r_resp;

  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_accept;
  logic            w_op_write;
  logic [1:0]      w_op_size;
  logic            w_op_unsigned;
  logic [31:0]     w_op_addr;
  logic [31:0]     w_op_wdata;
  logic [31:0]     w_offset;
  logic [AW-1:0]   w_index;
  logic            w_fault;
  logic [31:0]     w_rword;
  logic [3:0]      w_byte_en;
  logic [31:0]     w_lane_wdata;
  logic [31:0]     w_lane_rdata;

  assign w_accept = (r_state == ST_IDLE) && req_valid;

  // In IDLE the live request drives the datapath so a zero-wait access can
  // complete on the accept edge; otherwise the captured copy is used.
  assign w_op_write    = (r_state == ST_IDLE) ? req_write    : r_write;
  assign w_op_size     = (r_state == ST_IDLE) ? req_size     : r_size;
  assign w_op_unsigned = (r_state == ST_IDLE) ? req_unsigned : r_unsigned;
  assign w_op_addr     = (r_state == ST_IDLE) ? req_addr     : r_addr;
  assign w_op_wdata    = (r_state == ST_IDLE) ? req_wdata    : r_wdata;

  // Unsigned offset: addresses below ADDR_BASE wrap high and land out of range
  assign w_offset = w_op_addr - ADDR_BASE;
  assign w_index  = w_offset[AW+1:2];
  assign w_rword  = r_mem[w_index];

  // Only consulted at acceptance, when the op signals are the live request
  assign w_fault = (w_op_size == SIZE_X)
                 || is_misaligned(w_op_size, w_op_addr[1:0])
                 || ({1'b0, w_offset} >= SPAN_BYTES);

  mem_lane_align u_lane_align (
    .i_size     (w_op_size),
    .i_addr_lo  (w_op_addr[1:0]),
    .i_unsigned (w_op_unsigned),
    .i_wdata    (w_op_wdata),
    .i_rword    (w_rword),
    .o_byte_en  (w_byte_en),
    .o_wdata    (w_lane_wdata),
    .o_rdata    (w_lane_rdata)
  );

  // Next-state, wait counter and access-commit decode
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_do_access  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_fault) begin
            w_state_next = ST_RESP;
          end else if (ZERO_WAIT) begin
            w_state_next = ST_RESP;
            w_do_access  = 1'b1;
          end else begin
            w_state_next = ST_WAIT;
            w_cnt_next   = CNT_LOAD;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == CNT_ZERO) begin
          w_state_next = ST_RESP;
          w_do_access  = 1'b1;
        end else begin
          w_cnt_next   = r_cnt - CNT_ONE;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_RESP;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = CNT_ZERO;
      end
    endcase
  end

  // FSM state, counter, captured request and held response
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= CNT_ZERO;
      r_write      <= 1'b0;
      r_size       <= SIZE_B;
      r_unsigned   <= 1'b0;
      r_addr       <= 32'h0000_0000;
      r_wdata      <= 32'h0000_0000;
      r_resp.rdata <= 32'h0000_0000;
      r_resp.error <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_write      <= req_write;
        r_size       <= req_size;
        r_unsigned   <= req_unsigned;
        r_addr       <= req_addr;
        r_wdata      <= req_wdata;
        r_resp.rdata <= 32'h0000_0000;
        r_resp.error <= w_fault;
      end
      // Later assignment wins when a zero-wait access completes on the accept edge
      if (w_do_access) begin
        r_resp.rdata <= w_op_write ? 32'h0000_0000 : w_lane_rdata;
        r_resp.error <= 1'b0;
      end
    end
  end

  // RAM store port; contents survive reset, and a store pending at reset is dropped
  always_ff @(posedge clock) begin
    if (!reset && w_do_access && w_op_write) begin
      for (int i = 0; i < 4; i++) begin
        if (w_byte_en[i]) begin
          r_mem[w_index][8*i +: 8] <= w_lane_wdata[8*i +: 8];
        end
      end
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_resp.rdata;
  assign resp_error = r_resp.error;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: the driver runs a byte-addressed reference model at
// acceptance and queues the expected response; an independent monitor
// checks latency, stability while stalled and the returned data/error.
module tb_data_mem_responder;

  localparam int          DEPTH = 64;
  localparam int          WAITC = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_error;

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (WAITC),
    .ADDR_BASE   (BASE)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mb [DEPTH*4];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  bit         hold_low = 1'b0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference model on a flat byte array, little-endian.
  task automatic model(input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd, output exp_t e);
    int n;
    logic [31:0] off;
    logic [31:0] v;
    e.rdata = 32'h0; e.err = 1'b0; e.acc = cyc; e.lat = WAITC + 1;
    n = 1 << sz;
    off = addr - BASE;
    if (sz == 2'd3 || (addr % n) != 0 || off >= 32'(DEPTH * 4)) begin
      e.err = 1'b1;
      e.lat = 1;
      return;
    end
    if (wr) begin
      for (int i = 0; i < n; i++) mb[off + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mb[off + i];
      if (!uns && n < 4 && v[8*n-1]) begin
        for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
      end
      e.rdata = v;
    end
  endtask

  task automatic issue(input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input bit push, input bit keep_valid);
    int n;
    exp_t e;
    n = 0;
    @(negedge clock);
    while (!req_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready got 0 want 1 after %0d cycles", n);
      return;
    end
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    if (push) begin
      model(wr, sz, uns, addr, wd, e);
      exp_q.push_back(e);
    end
    @(posedge clock);
    #1;
    if (!keep_valid) begin
      req_valid    = 1'b0;
      req_write    = 1'($urandom_range(0, 1));
      req_size     = 2'($urandom_range(0, 3));
      req_unsigned = 1'($urandom_range(0, 1));
      req_addr     = $urandom;
      req_wdata    = $urandom;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: pending got %0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #1;
      resp_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: decoupled from stimulus, pops on each response handshake.
  initial begin
    bit          prev;
    logic [31:0] hold_d;
    logic        hold_e;
    exp_t        e;
    prev = 1'b0; hold_d = 32'h0; hold_e = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev = 1'b0;
      end else begin
        if (resp_valid) begin
          check32("req_ready_during_resp", 32'(req_ready), 32'h0);
          if (!prev) begin
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_resp: got rdata %h want no response", resp_rdata);
            end else begin
              check32("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
            end
            hold_d = resp_rdata;
            hold_e = resp_error;
          end else begin
            check32("stable_rdata", resp_rdata, hold_d);
            check32("stable_error", 32'(resp_error), 32'(hold_e));
          end
          if (resp_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check32("rdata", resp_rdata, e.rdata);
            check32("error", 32'(resp_error), 32'(e.err));
          end
        end
        prev = resp_valid && !resp_ready;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r;
    logic [31:0] a;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check32("reset_req_ready", 32'(req_ready), 32'h1);
    check32("reset_resp_valid", 32'(resp_valid), 32'h0);
    check32("reset_resp_rdata", resp_rdata, 32'h0);
    check32("reset_resp_error", 32'(resp_error), 32'h0);

    // Known RAM image
    for (int w = 0; w < DEPTH; w++) issue(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 1'b1, 1'b0);
    drain();

    // Directed cases
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0);
    issue(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b1, 1'b0);
    issue(1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5, 1'b1, 1'b0);
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0);
    issue(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b1, 1'b0);
    issue(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b1, 1'b0);
    issue(1'b1, 2'd1, 1'b0, 32'h12, 32'h00008001, 1'b1, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 1'b1, 1'b0);
    issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 1'b1, 1'b0);
    issue(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 1'b1, 1'b0);
    issue(1'b1, 2'd2, 1'b0, 32'(DEPTH * 4), 32'h12345678, 1'b1, 1'b0);
    issue(1'b1, 2'd3, 1'b0, 32'h20, 32'hFFFFFFFF, 1'b1, 1'b0);
    issue(1'b1, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h0BADF00D, 1'b1, 1'b0);
    drain();

    // Stall the response with a second request pending on the input
    hold_low = 1'b1;
    @(posedge clock);
    #2;
    issue(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1);
    req_write = 1'b1; req_size = 2'd2; req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    n = 0;
    while (!resp_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    check32("hold_resp_seen", 32'(resp_valid), 32'h1);
    repeat (5) @(negedge clock);
    req_valid = 1'b0;
    hold_low = 1'b0;
    drain();

    // Randomized traffic, including faults
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 15);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 7));
      else             a = 32'($urandom_range(0, DEPTH * 4 - 1));
      issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            a, $urandom, 1'b1, 1'b0);
    end
    drain();

    // Full read-back
    for (int w = 0; w < DEPTH; w++) issue(1'b0, 2'd2, 1'b0, 32'(w * 4), 32'h0, 1'b1, 1'b0);
    drain();

    // Reset while a store is waiting: store must be dropped
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0);
    drain();
    issue(1'b1, 2'd2, 1'b0, 32'h20, 32'h55, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check32("abort_resp_valid", 32'(resp_valid), 32'h0);
    check32("abort_req_ready", 32'(req_ready), 32'h1);
    issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
